seq_detector_param: RTL

// - Parametrised Moore serial-pattern detector; generalises the fixed 3-bit "101" overlap detector.
// - Runtime-loadable pattern, length 1..MAX_LEN, overlap or non-overlap mode, bit-valid gating.
// - Saturating match counter with a sticky saturation flag.
// - Sits on a serial bit stream between a deserialiser front-end and the control/status logic.

---
 rtl/seq_det_pkg.sv | 20 ++
 rtl/seq_match_counter.sv | 48 ++++
 rtl/seq_detector_param.sv | 118 +++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_det_pkg: shared state encoding and width helper for the          |
// | parametrised serial pattern detector.                    Rev 1.0     |
// +----------------------------------------------------------------------+
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        HIT  = 2'd2
    } state_t;

    // Width needed to hold a length in 0..max_len inclusive.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_match_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_match_counter: saturating match counter with sticky saturation   |
// | flag; clear wins over increment but still counts a coincident hit.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seq_match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_sat
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic [CNT_W-1:0] w_cnt_n;

    always_comb begin
        w_cnt_n = r_cnt;
        if (i_clr) begin
            w_cnt_n = i_inc ? CNT_W'(1) : '0;
        end else if (i_inc && (r_cnt != c_CNT_MAX)) begin
            w_cnt_n = r_cnt + CNT_W'(1);
        end
    end

    // A clear-with-hit lands on 1, which can never be all-ones for CNT_W >= 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else begin
            r_cnt <= w_cnt_n;
            r_sat <= (i_clr ? 1'b0 : r_sat) | (w_cnt_n == c_CNT_MAX);
        end
    end

    assign o_cnt = r_cnt;
    assign o_sat = r_sat;

endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_detector_param: Moore serial pattern detector with runtime       |
// | pattern/length/overlap config and a saturating match count. Rev 1.0  |
// +----------------------------------------------------------------------+
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter  int                 MAX_LEN     = 8,
    parameter  int                 CNT_W       = 8,
    parameter  logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(3'b101),
    parameter  int                 DEF_LEN     = 3,
    parameter  bit                 DEF_OVERLAP = 1'b1,
    localparam int                 LEN_W       = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               x,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clr_cnt,
    output logic               y,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat
);

    localparam logic [LEN_W-1:0] c_MAX_FILL  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] c_DEF_LEN   = LEN_W'(DEF_LEN);
    localparam state_t           c_RST_STATE =
        ((DEF_LEN >= 1) && (DEF_LEN <= MAX_LEN)) ? HUNT : IDLE;

    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    // The oldest history bit is never compared after the next shift, so it is not stored.
    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    state_t             r_state;

    state_t             w_state_n;
    logic [MAX_LEN-1:0] w_hist_n;
    logic [LEN_W-1:0]   w_fill_inc;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_cfg_valid;
    logic               w_accept;
    logic               w_match;
    logic               w_hit;

    assign w_hist_n    = {r_hist, x};
    assign w_fill_inc  = (r_fill == c_MAX_FILL) ? r_fill : (r_fill + LEN_W'(1));
    assign w_cfg_valid = (cfg_len != '0) && (cfg_len <= c_MAX_FILL);
    assign w_accept    = en && !cfg_load && (r_state != IDLE);

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_match = (((w_hist_n ^ r_pattern) & w_mask) == '0);
    assign w_hit   = w_accept && (w_fill_inc >= r_len) && w_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pattern <= DEF_PATTERN;
            r_len     <= c_DEF_LEN;
            r_overlap <= DEF_OVERLAP;
            r_hist    <= '0;
            r_fill    <= '0;
        end else if (cfg_load) begin
            r_pattern <= cfg_pattern;
            r_len     <= cfg_len;
            r_overlap <= cfg_overlap;
            r_hist    <= '0;
            r_fill    <= '0;
        end else if (w_accept) begin
            r_hist <= w_hist_n[MAX_LEN-2:0];
            // Non-overlap restarts the window so the next match needs len fresh bits.
            r_fill <= (w_hit && !r_overlap) ? '0 : w_fill_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_RST_STATE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        if (cfg_load) begin
            w_state_n = w_cfg_valid ? HUNT : IDLE;
        end else if (w_accept) begin
            w_state_n = w_hit ? HIT : HUNT;
        end
    end

    assign y = (r_state == HIT);

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (clr_cnt),
        .i_inc (w_hit),
        .o_cnt (match_cnt),
        .o_sat (cnt_sat)
    );

endmodule
`default_nettype wire
